// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx -- receive-only I2C slave (write transfers only).
//
// Oversamples SCL/SDA with the system clock, detects START/STOP, matches a
// 7-bit address with R/W=0, ACKs the address and every following data byte,
// and presents each received byte on data_out with a one-cycle data_valid.
//
// Ports
//   clk         system clock, all logic on its rising edge
//   reset       synchronous active-high reset
//   scl         I2C clock from the bus master (sampled, not used as a clock)
//   sda_in      I2C data as seen on the bus
//   my_addr     this slave's address, sampled at the address compare
//   sda_oe      1 = pull SDA low (ACK), 0 = release
//   data_out    last complete data byte received
//   data_valid  one-cycle pulse when data_out updates
//   addr_match  high from the address ACK until the next START or STOP
//   busy        high between START and STOP
//   state       current FSM state (IDLE=0 ADDR=1 ACK_A=2 DATA=3 ACK_D=4 IGNORE=5)
module i2c_slave_rx #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    input  logic              sda_in,
    input  logic [ADDR_W-1:0] my_addr,
    output logic              sda_oe,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              addr_match,
    output logic              busy,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        DATA   = 3'd3,
        ACK_D  = 3'd4,
        IGNORE = 3'd5
    } state_t;

    state_t cur, nxt;

    logic       scl_m, scl_s, scl_d;
    logic       sda_m, sda_s, sda_d;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       ack_on;   // ACK currently driven inside ACK_A / ACK_D

    logic       scl_rise, scl_fall, start_det, stop_det, last_bit, addr_ok;
    logic [7:0] byte_in;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    // Reset to 1 so the block comes up seeing an idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_m <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
            sda_m <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_m <= scl;    scl_s <= scl_m;  scl_d <= scl_s;
            sda_m <= sda_in; sda_s <= sda_m;  sda_d <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

    // Byte as it will look once the bit on this rising edge is shifted in.
    assign byte_in  = {shreg[6:0], sda_s};
    assign last_bit = scl_rise && (bit_cnt == 4'd7);
    assign addr_ok  = (ADDR_W'(byte_in[7:1]) == my_addr) && !byte_in[0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    // Next state: bus conditions override any bit activity in the same cycle.
    always_comb begin
        nxt = cur;
        if (stop_det)       nxt = IDLE;
        else if (start_det) nxt = ADDR;
        else begin
            case (cur)
                ADDR:         if (last_bit) nxt = addr_ok ? ACK_A : IGNORE;
                DATA:         if (last_bit) nxt = ACK_D;
                ACK_A, ACK_D: if (scl_fall && ack_on) nxt = DATA;
                default:      nxt = cur;
            endcase
        end
    end

    // Outputs; sda_oe is gated by state so it can only appear in an ACK slot.
    always_comb begin
        sda_oe = ack_on && (cur == ACK_A || cur == ACK_D);
        busy   = (cur != IDLE);
        state  = cur;
    end

    // Shift register, bit counter, ACK phase and received-byte registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            ack_on     <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (start_det || stop_det) begin
                // Abort: any partial byte and pending ACK are dropped.
                bit_cnt    <= 4'd0;
                shreg      <= 8'h00;
                ack_on     <= 1'b0;
                addr_match <= 1'b0;
            end else begin
                case (cur)
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                            if (cur == DATA && last_bit) begin
                                data_out   <= byte_in;
                                data_valid <= 1'b1;
                            end
                        end
                    end
                    ACK_A, ACK_D: begin
                        // First SCL fall drives ACK, second releases it.
                        if (scl_fall) begin
                            ack_on <= ~ack_on;
                            if (cur == ACK_A && !ack_on) addr_match <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Testbench for i2c_slave_rx: bit-banged bus master with an open-drain SDA
// model, directed scenarios followed by randomized write transfers.
module tb_i2c_slave_rx;

    localparam int HP = 6;   // clk cycles per SCL phase step

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [6:0] my_addr = 7'h12;
    logic       sda_line;
    logic       sda_oe, data_valid, addr_match, busy;
    logic [7:0] data_out;
    logic [2:0] state;

    int         n_chk = 0;
    int         n_fail = 0;
    int         dv_cnt = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] obs_q[$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(.ADDR_W(7)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_line),
        .my_addr(my_addr), .sda_oe(sda_oe), .data_out(data_out),
        .data_valid(data_valid), .addr_match(addr_match), .busy(busy),
        .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: collect data_valid bytes, police pulse width and ACK legality.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                dv_cnt++;
                obs_q.push_back(data_out);
                chk("dv_one_cycle", dv_prev, 0);
            end
            if (sda_oe) chk("oe_only_in_ack", (state == 3'd2 || state == 3'd4), 1);
        end
        dv_prev = data_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START from either an idle bus or SCL low (repeated START).
    task automatic bus_start();
        sda_m = 1'b1; tick(HP); scl = 1'b1; tick(HP);
        sda_m = 1'b0; tick(HP); scl = 1'b0; tick(HP);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(HP); scl = 1'b1; tick(HP);
        sda_m = 1'b1; tick(HP);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; tick(HP); scl = 1'b1; tick(HP); scl = 1'b0; tick(HP);
    endtask

    // Eight bits MSB first, then an ACK slot where the master releases SDA.
    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(HP); scl = 1'b1; tick(HP/2);
        acked = ~sda_line;
        tick(HP - HP/2); scl = 1'b0; tick(HP);
    endtask

    // Reference rule: a write to this slave's address is acknowledged.
    function automatic logic exp_ack(input logic [7:0] ab, input logic [6:0] ma);
        return (ab[7:1] == ma) && (ab[0] == 1'b0);
    endfunction

    initial begin
        logic       ack;
        logic       e;
        int         dv0;
        int         nb;
        logic [7:0] ab, d;
        logic [7:0] exp_q[$];

        // Reset values
        tick(4);
        chk("rst_state", state, 0);      chk("rst_oe", sda_oe, 0);
        chk("rst_data", data_out, 8'h00); chk("rst_dv", data_valid, 0);
        chk("rst_match", addr_match, 0); chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick(4);

        // Addressed write of one byte
        dv0 = dv_cnt;
        bus_start();
        chk("w1_busy", busy, 1); chk("w1_state_addr", state, 1);
        send_byte(8'h24, ack);
        chk("w1_addr_ack", ack, 1); chk("w1_match", addr_match, 1); chk("w1_state_data", state, 3);
        send_byte(8'hAA, ack);
        chk("w1_data_ack", ack, 1); chk("w1_data", data_out, 8'hAA);
        bus_stop(); tick(HP);
        chk("w1_dv_count", dv_cnt - dv0, 1); chk("w1_idle", state, 0);
        chk("w1_busy_off", busy, 0); chk("w1_match_off", addr_match, 0);

        // Wrong address
        dv0 = dv_cnt;
        bus_start();
        send_byte(8'h58, ack);
        chk("w2_nack", ack, 0); chk("w2_ignore", state, 5);
        send_byte(8'h33, ack);
        chk("w2_data_nack", ack, 0); chk("w2_still_ignore", state, 5);
        bus_stop(); tick(HP);
        chk("w2_no_dv", dv_cnt - dv0, 0); chk("w2_idle", state, 0);

        // Own address with read bit
        bus_start();
        send_byte(8'h25, ack);
        chk("w3_read_nack", ack, 0); chk("w3_ignore", state, 5);
        bus_stop(); tick(HP);

        // Two bytes, no STOP, then partial byte aborted by repeated START
        dv0 = dv_cnt; obs_q.delete();
        bus_start();
        send_byte(8'h24, ack); chk("w4_addr_ack", ack, 1);
        send_byte(8'h55, ack); chk("w4_ack1", ack, 1); chk("w4_data1", data_out, 8'h55);
        send_byte(8'h00, ack); chk("w4_ack2", ack, 1); chk("w4_data2", data_out, 8'h00);
        chk("w4_dv_count", dv_cnt - dv0, 2);
        chk("w4_obs0", obs_q.size() > 0 ? obs_q[0] : 8'hxx, 8'h55);
        chk("w4_obs1", obs_q.size() > 1 ? obs_q[1] : 8'hxx, 8'h00);
        dv0 = dv_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_start();
        chk("w5_rs_addr", state, 1); chk("w5_rs_match", addr_match, 0);
        send_byte(8'h24, ack); chk("w5_addr_ack", ack, 1);
        send_byte(8'h3C, ack); chk("w5_ack", ack, 1);
        bus_stop(); tick(HP);
        chk("w5_dv_count", dv_cnt - dv0, 1); chk("w5_data", data_out, 8'h3C);

        // Reset during data bit 5
        dv0 = dv_cnt;
        bus_start();
        send_byte(8'h24, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        sda_m = 1'b1; tick(2);
        reset = 1'b1; tick(1);
        chk("r_state", state, 0);      chk("r_oe", sda_oe, 0);
        chk("r_data", data_out, 8'h00); chk("r_dv", data_valid, 0);
        chk("r_match", addr_match, 0); chk("r_busy", busy, 0);
        tick(2); reset = 1'b0;
        tick(HP); scl = 1'b1; tick(HP); scl = 1'b0; tick(HP);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("r_ignored", state, 0); chk("r_no_dv", dv_cnt - dv0, 0);
        bus_start();
        send_byte(8'h24, ack); chk("r2_addr_ack", ack, 1);
        send_byte(8'hAA, ack); chk("r2_data_ack", ack, 1);
        bus_stop(); tick(HP);
        chk("r2_data", data_out, 8'hAA); chk("r2_dv_count", dv_cnt - dv0, 1);
        chk("r2_idle", state, 0);

        // Randomized write transfers against the reference rule
        for (int t = 0; t < 20; t++) begin
            my_addr = 7'($urandom);
            if ($urandom_range(0, 1) == 1) ab = {my_addr, 1'($urandom_range(0, 3) == 0)};
            else                           ab = 8'($urandom);
            e  = exp_ack(ab, my_addr);
            nb = $urandom_range(1, 3);
            exp_q.delete(); obs_q.delete(); dv0 = dv_cnt;
            bus_start();
            send_byte(ab, ack);
            chk("rnd_addr_ack", ack, e);
            for (int j = 0; j < nb; j++) begin
                d = 8'($urandom);
                send_byte(d, ack);
                chk("rnd_data_ack", ack, e);
                if (e) begin
                    exp_q.push_back(d);
                    chk("rnd_data_out", data_out, d);
                end
            end
            bus_stop(); tick(HP);
            chk("rnd_dv_count", dv_cnt - dv0, exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                chk("rnd_obs_byte", k < obs_q.size() ? obs_q[k] : 8'hxx, exp_q[k]);
            chk("rnd_idle", state, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter ADDR_W, default 7, width of the slave address.
REQ-002 clk  input  1  system clock; all logic on posedge clk; SCL/SDA are sampled, never used as clocks.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 scl  input  1  I2C clock from bus master.
REQ-005 sda_in  input  1  I2C data from bus.
REQ-006 my_addr  input  ADDR_W  this slave's address; sampled only at the address compare.
REQ-007 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-008 data_out  output  8  last received data byte.
REQ-009 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-010 addr_match  output  1  high from address ACK until STOP or START.
REQ-011 busy  output  1  high between START and STOP.
REQ-012 state  output  3  current FSM state encoding.

Function
REQ-013 scl and sda_in SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized versions (scl_s, sda_s) and their 1-cycle-delayed copies.
REQ-014 START SHALL be sda_s falling while scl_s is high; STOP SHALL be sda_s rising while scl_s is high.
REQ-015 Bits SHALL be sampled on the scl_s rising edge, MSB first; a 4-bit counter SHALL track bits 0..8.
REQ-016 FSM states SHALL be IDLE=0, ADDR=1, ACK_A=2, DATA=3, ACK_D=4, IGNORE=5.
REQ-017 IDLE: wait for START, then go to ADDR with the bit count cleared and busy=1.
REQ-018 ADDR: shift 8 bits (7 address bits plus R/W). After the 8th rising edge, go to ACK_A if the address equals my_addr and R/W=0; otherwise go to IGNORE.
REQ-019 ACK_A: assert sda_oe on the first scl_s falling edge after entry; release it on the next scl_s falling edge; then go to DATA with addr_match=1.
REQ-020 DATA: shift 8 bits. On the 8th rising edge, load data_out on the next clk. Pulse data_valid in that same cycle. Go to ACK_D.
REQ-021 ACK_D: drive sda_oe with the same falling-edge timing as ACK_A, then return to DATA for the next byte.
REQ-022 IGNORE: sda_oe=0 and no data_valid pulses until START or STOP.
REQ-023 A START (repeated start) in any state except IDLE SHALL go to ADDR. It SHALL clear the bit count, addr_match and sda_oe, and SHALL discard any partial byte.
REQ-024 A STOP in any state SHALL go to IDLE. It SHALL clear sda_oe, addr_match and busy, and SHALL discard any partial byte.
REQ-025 START/STOP detection SHALL take priority over bit sampling in the same cycle.
REQ-026 sda_oe SHALL never be asserted outside ACK_A or ACK_D.
REQ-027 data_out SHALL hold its value until the next complete byte.

Reset
REQ-028 While reset=1, on posedge clk: state=IDLE, sda_oe=0, data_out=8'h00, data_valid=0, addr_match=0, busy=0, bit counter=0, shift register=0; synchronizer flops SHALL be set to 1 (idle bus).
REQ-029 Reset asserted mid-transfer SHALL abort the transfer; after release, the block SHALL ignore the bus until a new START.

Verification
REQ-030 my_addr=7'h12; START, address 0x12 with W, data 0xAA, STOP -> ACK after the address and after the data; data_out=8'hAA; exactly one data_valid pulse; final state IDLE.
REQ-031 my_addr=7'h12; bus sends address 0x2C -> sda_oe stays 0; state=IGNORE until STOP; no data_valid.
REQ-032 my_addr=7'h12; address 0x12 with R/W=1 -> NACK (sda_oe stays 0), state=IGNORE.
REQ-033 Address 0x12, bytes 0x55 then 0x00 without STOP -> two data_valid pulses, data_out=8'h55 then 8'h00, two data ACKs.
REQ-034 Repeated START after 4 data bits, then address 0x12 and 0x3C -> the partial byte produces no pulse; data_out=8'h3C.
REQ-035 Reset pulsed during data bit 5 -> all outputs return to their REQ-028 values; the next full transfer of 0xAA completes correctly.
